// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: owns HI/LO, runs mult/multu/div/divu as a
// fixed-latency busy period, and serves mthi/mtlo/mfhi/mflo.
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        E_MDU_start,
  input  logic [3:0]  E_MDU_op,
  input  logic [31:0] E_MDU_a,
  input  logic [31:0] E_MDU_b,
  output logic        E_MDU_busy,
  output logic [31:0] E_MDU_out
);

  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  // Signed divide done on magnitudes so that 0x80000000 / -1 wraps cleanly
  // to 0x80000000 with remainder 0. Returns {remainder, quotient}.
  function automatic logic [63:0] sdiv(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] q_u;
    logic [31:0] r_u;
    logic [31:0] q;
    logic [31:0] r;
    mag_a = a[31] ? (32'd0 - a) : a;
    mag_b = b[31] ? (32'd0 - b) : b;
    q_u   = mag_a / mag_b;
    r_u   = mag_a % mag_b;
    q     = (a[31] ^ b[31]) ? (32'd0 - q_u) : q_u;
    r     = a[31] ? (32'd0 - r_u) : r_u;
    return {r, q};
  endfunction

  logic [31:0]        r_hi;
  logic [31:0]        r_lo;
  logic [31:0]        r_hi_nx;
  logic [31:0]        r_lo_nx;
  logic               r_div0;
  logic [CNT_W-1:0]   r_cnt;

  logic signed [63:0] w_sa;
  logic signed [63:0] w_sb;
  logic signed [63:0] w_sprod;
  logic [63:0]        w_uprod;
  logic [31:0]        w_b_nz;
  logic [63:0]        w_sdiv;
  logic               w_busy;
  logic               w_launch;
  logic               w_is_div;
  logic [31:0]        w_hi_nx;
  logic [31:0]        w_lo_nx;

  assign w_sa    = {{32{E_MDU_a[31]}}, E_MDU_a};
  assign w_sb    = {{32{E_MDU_b[31]}}, E_MDU_b};
  assign w_sprod = w_sa * w_sb;
  assign w_uprod = {32'd0, E_MDU_a} * {32'd0, E_MDU_b};
  // Divisor forced nonzero; the div0 flag suppresses the commit anyway.
  assign w_b_nz  = (E_MDU_b == 32'd0) ? 32'd1 : E_MDU_b;
  assign w_sdiv  = sdiv(E_MDU_a, w_b_nz);
  assign w_busy  = (r_cnt != '0);
  assign w_launch = E_MDU_start && !w_busy &&
                    (E_MDU_op >= OP_MULT) && (E_MDU_op <= OP_DIVU);
  assign w_is_div = (E_MDU_op == OP_DIV) || (E_MDU_op == OP_DIVU);

  // Select the pending HI/LO result for the operation being launched.
  always_comb begin
    w_hi_nx = 32'd0;
    w_lo_nx = 32'd0;
    case (E_MDU_op)
      OP_MULT:  {w_hi_nx, w_lo_nx} = w_sprod;
      OP_MULTU: {w_hi_nx, w_lo_nx} = w_uprod;
      OP_DIV:   {w_hi_nx, w_lo_nx} = w_sdiv;
      OP_DIVU: begin
        w_lo_nx = E_MDU_a / w_b_nz;
        w_hi_nx = E_MDU_a % w_b_nz;
      end
      default: ;
    endcase
  end

  // HI/LO, busy counter and pending result: launch, count down, commit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
      r_hi_nx <= 32'd0;
      r_lo_nx <= 32'd0;
      r_div0  <= 1'b0;
      r_cnt   <= '0;
    end else if (w_busy) begin
      r_cnt <= r_cnt - 1'b1;
      if (r_cnt == CNT_W'(1) && !r_div0) begin
        r_hi <= r_hi_nx;
        r_lo <= r_lo_nx;
      end
    end else if (w_launch) begin
      r_hi_nx <= w_hi_nx;
      r_lo_nx <= w_lo_nx;
      r_div0  <= w_is_div && (E_MDU_b == 32'd0);
      r_cnt   <= w_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    end else if (E_MDU_op == OP_MTHI) begin
      r_hi <= E_MDU_a;
    end else if (E_MDU_op == OP_MTLO) begin
      r_lo <= E_MDU_a;
    end
  end

  assign E_MDU_busy = w_busy;

  // mf* reads the committed registers only, never the pending result.
  always_comb begin
    E_MDU_out = 32'd0;
    if (E_MDU_op == OP_MFHI)      E_MDU_out = r_hi;
    else if (E_MDU_op == OP_MFLO) E_MDU_out = r_lo;
  end

endmodule
